// File: rtl/ram_arb_pkg.sv
// ram_arb_pkg: shared state encoding and RAM command opcodes for ram_arbiter.
// Rev 1.0
`default_nettype none

package ram_arb_pkg;

  typedef enum logic [2:0] {IDLE, ADDR, DATA, RD_WAIT, RESP} arb_state_e;

  localparam logic [1:0] CMD_WR_ADDR = 2'b00;
  localparam logic [1:0] CMD_WR_DATA = 2'b01;
  localparam logic [1:0] CMD_RD_ADDR = 2'b10;
  localparam logic [1:0] CMD_RD_DATA = 2'b11;

endpackage

`default_nettype wire

// File: rtl/ram_arbiter_rr.sv
// rr_arb2: two-way round-robin grant; the pointer moves to the loser on each accept.
// Rev 1.0
`default_nettype none

module rr_arb2 (
  input  logic       clk,
  input  logic       rst_n,
  input  logic [1:0] req,
  input  logic       en,
  output logic [1:0] grant
);

  logic rr;

  always_comb begin
    grant = req;
    if (req == 2'b11) grant = rr ? 2'b10 : 2'b01;
  end

  // Winner 0 hands priority to 1 and vice versa, so rr simply becomes grant[0].
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)               rr <= 1'b0;
    else if (en && |grant)    rr <= grant[0];
  end

endmodule

`default_nettype wire

// File: rtl/ram_arbiter.sv
// ram_arbiter: round-robin arbiter that serialises two requesters' read/write
// transactions into command words for a single-port RAM. Rev 1.0
`default_nettype none

module ram_arbiter
  import ram_arb_pkg::*;
#(
  parameter int ADDR_SIZE = 8,
  parameter int TIMEOUT   = 15
) (
  input  logic                   clk,
  input  logic                   rst_n,
  input  logic [1:0]             req_valid,
  output logic [1:0]             req_ready,
  input  logic [1:0]             req_wr,
  input  logic [2*ADDR_SIZE-1:0] req_addr,
  input  logic [2*ADDR_SIZE-1:0] req_wdata,
  output logic [1:0]             rsp_valid,
  output logic [ADDR_SIZE-1:0]   rsp_rdata,
  output logic                   rsp_err,
  output logic [ADDR_SIZE+1:0]   ram_din,
  output logic                   ram_rx_valid,
  input  logic                   ram_tx_valid,
  input  logic [ADDR_SIZE-1:0]   ram_dout
);

  localparam int CW = $clog2(TIMEOUT + 1);

  arb_state_e           state;
  logic [1:0]           grant;
  logic                 accept;
  logic                 sel;
  logic                 wr_q;
  logic                 owner_q;
  logic [ADDR_SIZE-1:0] addr_q;
  logic [ADDR_SIZE-1:0] wdata_q;
  logic [ADDR_SIZE-1:0] sel_addr;
  logic [ADDR_SIZE-1:0] sel_wdata;
  logic [CW-1:0]        cnt;

  assign accept    = (state == IDLE) && (|req_valid);
  assign req_ready = (state == IDLE) ? grant : 2'b00;
  assign sel       = grant[1];
  assign sel_addr  = sel ? req_addr[2*ADDR_SIZE-1:ADDR_SIZE]  : req_addr[ADDR_SIZE-1:0];
  assign sel_wdata = sel ? req_wdata[2*ADDR_SIZE-1:ADDR_SIZE] : req_wdata[ADDR_SIZE-1:0];

  rr_arb2 u_rr (
    .clk   (clk),
    .rst_n (rst_n),
    .req   (req_valid),
    .en    (accept),
    .grant (grant)
  );

  // Outputs are loaded on the transition into the state that presents them.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state        <= IDLE;
      wr_q         <= 1'b0;
      owner_q      <= 1'b0;
      addr_q       <= '0;
      wdata_q      <= '0;
      cnt          <= '0;
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
    end else begin
      ram_din      <= '0;
      ram_rx_valid <= 1'b0;
      rsp_valid    <= 2'b00;
      rsp_rdata    <= '0;
      rsp_err      <= 1'b0;
      case (state)
        IDLE: begin
          if (accept) begin
            owner_q      <= sel;
            wr_q         <= req_wr[sel];
            addr_q       <= sel_addr;
            wdata_q      <= sel_wdata;
            ram_din      <= {(req_wr[sel] ? CMD_WR_ADDR : CMD_RD_ADDR), sel_addr};
            ram_rx_valid <= 1'b1;
            state        <= ADDR;
          end
        end
        ADDR: begin
          ram_din      <= {(wr_q ? CMD_WR_DATA : CMD_RD_DATA), (wr_q ? wdata_q : '0)};
          ram_rx_valid <= 1'b1;
          state        <= DATA;
        end
        DATA: begin
          if (wr_q) begin
            rsp_valid <= {owner_q, ~owner_q};
            state     <= RESP;
          end else begin
            cnt   <= '0;
            state <= RD_WAIT;
          end
        end
        RD_WAIT: begin
          if (ram_tx_valid) begin
            rsp_valid <= {owner_q, ~owner_q};
            rsp_rdata <= ram_dout;
            state     <= RESP;
          end else begin
            cnt <= cnt + 1'b1;
            if (cnt == CW'(TIMEOUT - 1)) begin
              rsp_valid <= {owner_q, ~owner_q};
              rsp_err   <= 1'b1;
              state     <= RESP;
            end
          end
        end
        RESP:    state <= IDLE;
        default: state <= IDLE;
      endcase
    end
  end

endmodule

`default_nettype wire
